// File: rtl/uart_fifo_tx.sv
// 8N1-style serial transmitter that drains a first-word-fall-through FIFO.
// Start bit, WIDTH data bits LSB first, stop bit; back-to-back frames with no idle gap.
module uart_fifo_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               pop_q, pop_d;
    logic               bit_done;
    logic               load;

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop_d   = 1'b0;
        load    = 1'b0;

        if (state_q != IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                load   = !fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        tx_d  = shift_q[idx_q + 1'b1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load drops tx on this same edge so the start bit lasts a full bit time.
        if (load) begin
            shift_d = fifo_data;
            state_d = START;
            baud_d  = '0;
            idx_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            pop_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            pop_q   <= pop_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign fifo_pop = pop_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx (CLKS_PER_BIT=4, WIDTH=8) fed by a small FWFT FIFO model.
module tb_uart_fifo_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       tx;
    logic       busy;

    logic [7:0] mem [0:255];
    int         wr = 0;
    int         rd = 0;
    int         pop_cnt = 0;
    int         pop_empty = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_fifo_tx #(.CLKS_PER_BIT(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy)
    );

    // First-word-fall-through FIFO model: head word visible while non-empty.
    assign fifo_empty = (wr == rd);
    assign fifo_data  = mem[rd[7:0]];

    always @(posedge clk) begin
        if (fifo_pop) begin
            pop_cnt <= pop_cnt + 1;
            if (wr == rd) pop_empty <= pop_empty + 1;
            else          rd <= rd + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr[7:0]] = w;
        wr = wr + 1;
    endtask

    // Called at a negedge; returns positioned at the first negedge with tx low.
    task automatic wait_start(input int max_wait, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        check_val("start_seen", {31'd0, tx}, 32'd0);
    endtask

    // Checks one full 40-cycle frame; returns at the negedge after its last cycle.
    task automatic frame(input logic [7:0] w);
        logic exp_tx;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_tx = 1'b0;
            else if (k < 36) exp_tx = w[(k-4)/4];
            else             exp_tx = 1'b1;
            check_val($sformatf("tx_%02h_c%0d", w, k), {31'd0, tx}, {31'd0, exp_tx});
            check_val($sformatf("busy_%02h_c%0d", w, k), {31'd0, busy}, 32'd1);
            check_val($sformatf("pop_%02h_c%0d", w, k), {31'd0, fifo_pop}, (k == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int waited;
        int bad;
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset held three cycles with a word already waiting.
        rst = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_tx", {31'd0, tx}, 32'd1);
            check_val("rst_busy", {31'd0, busy}, 32'd0);
            check_val("rst_pop", {31'd0, fifo_pop}, 32'd0);
        end
        check_val("rst_pop_cnt", pop_cnt, 0);
        rst = 1'b0;

        // Single frame 0xA5 loads on the first edge after reset release.
        wait_start(4, waited);
        check_val("a5_latency", waited, 1);
        frame(8'hA5);
        check_val("a5_end_tx", {31'd0, tx}, 32'd1);
        check_val("a5_end_busy", {31'd0, busy}, 32'd0);
        check_val("a5_pops", pop_cnt, 1);
        check_val("a5_empty", {31'd0, fifo_empty}, 32'd1);

        // Back-to-back 0x00, 0xFF.
        push(8'h00);
        push(8'hFF);
        wait_start(4, waited);
        check_val("b2b_latency", waited, 1);
        frame(8'h00);
        wait_start(0, waited);
        check_val("b2b_gap", waited, 0);
        frame(8'hFF);
        check_val("b2b_end_tx", {31'd0, tx}, 32'd1);
        check_val("b2b_end_busy", {31'd0, busy}, 32'd0);
        check_val("b2b_pops", pop_cnt, 3);

        // Idle with empty FIFO for 200 cycles.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0) bad++;
        end
        check_val("idle_bad_cycles", bad, 0);
        check_val("idle_pops", pop_cnt, 3);

        // Reset in frame cycle 15 with the next word pending.
        push(8'h3C);
        wait_start(4, waited);
        for (int k = 0; k < 15; k++) @(negedge clk);
        push(8'h5A);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_tx", {31'd0, tx}, 32'd1);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_pop", {31'd0, fifo_pop}, 32'd0);
        check_val("midrst_pops", pop_cnt, 4);
        rst = 1'b0;
        wait_start(4, waited);
        check_val("midrst_latency", waited, 1);
        frame(8'h5A);
        check_val("midrst_end_pops", pop_cnt, 5);

        // Four-deep FIFO filled with four words, drained in order.
        for (int i = 0; i < 4; i++) push(words[i]);
        check_val("fifo_depth", wr - rd, 4);
        for (int i = 0; i < 4; i++) begin
            wait_start(4, waited);
            check_val($sformatf("fifo_gap_%0d", i), waited, (i == 0) ? 1 : 0);
            frame(words[i]);
        end
        check_val("fifo_pops", pop_cnt, 9);
        check_val("fifo_empty_end", {31'd0, fifo_empty}, 32'd1);
        check_val("fifo_end_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        check_val("fifo_pops_after", pop_cnt, 9);
        check_val("pop_while_empty", pop_empty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
UART 8N1-style transmitter that drains a first-word-fall-through FIFO (fifo_buff) on the output side of the hub.
- Takes the word at the FIFO head whenever the FIFO is non-empty and pulses the FIFO read strobe once per word.
- Serialises the word as start bit, data LSB first, stop bit, at CLKS_PER_BIT clocks per bit.
- Sits between a fifo_buff (data_out/empty/out_clk) and the tx pin of a hub port.

Parameters:
CLKS_PER_BIT, 104, clk cycles per serial bit; legal range is 2 to 65535.
WIDTH, 8, data bits per frame; must match the FIFO WIDTH; legal range is 5 to 16.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
fifo_data  input  WIDTH  FIFO head word (fifo_buff data_out); valid whenever fifo_empty=0.
fifo_empty  input  1  FIFO empty flag.
fifo_pop  output  1  one-cycle read strobe; drives fifo_buff out_clk.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values: tx=1, fifo_pop=0, busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- rst is sampled on posedge clk only.
- Registered outputs: tx, busy and fifo_pop are registered; there are no combinational paths from inputs to outputs.
- State IDLE:
  - tx=1, busy=0.
  - On an edge with fifo_empty=0, latch fifo_data into the shift register, go to START, and set tx=0, busy=1, fifo_pop=1.
- fifo_pop pulse:
  - High for exactly the one cycle after the load edge; cleared at the following edge.
  - Never high while fifo_empty was 1 at the load edge.
  - At most one pulse per frame.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1 in each bit state; wraps to 0 on the bit transition.
  - Width is the minimum needed to hold CLKS_PER_BIT-1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit[index], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit WIDTH-1, go to STOP.
  - Bit index width is the minimum needed to hold WIDTH-1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle edge, if fifo_empty=0, load the next word directly into START: no idle gap, and a new fifo_pop pulse.
  - Otherwise go to IDLE and clear busy.
- Frame length is exactly (WIDTH+2)*CLKS_PER_BIT cycles. The tx low edge occurs on the load edge.
- fifo_empty changing mid-frame: ignored; it is sampled only in IDLE and on the last STOP cycle.
- fifo_data changing mid-frame: no effect; the word is held in the shift register.
- Reset mid-frame:
  - At the next edge, tx=1, busy=0, state=IDLE; the partial frame is abandoned and the word is lost.
  - A fifo_pop already high in the current cycle completes normally; no further pop is generated.
- Reset and fifo_empty=0 on the same edge: reset wins. No load and no pop that edge; loading resumes on the first edge after rst deasserts.

Test Plan:
1. Reset: assert rst for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_pop=0 throughout; no pop during reset.
2. Single frame, CLKS_PER_BIT=4, WIDTH=8, one word 0xA5:
   - tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1 for 4 cycles.
   - Exactly one fifo_pop pulse, in cycle 1 of the frame.
   - busy high for exactly 40 cycles.
3. Back-to-back: FIFO holds 0x00 then 0xFF -> two frames with no idle cycle between them, pops exactly 40 cycles apart, busy high for 80 consecutive cycles, final stop bit high.
4. Idle: fifo_empty held at 1 for 200 cycles -> tx constantly 1, zero pops, busy=0.
5. Reset mid-frame: assert rst for 1 cycle at frame cycle 15 -> tx=1 and busy=0 the next cycle, no extra pop. With a word pending after release, a clean new frame starts on the first non-reset edge.
6. Integration with fifo_buff LENGTH=4: write 0x11, 0x22, 0x33, 0x44 -> serial output in that order, exactly 4 pops, FIFO empty after the 4th, and no pop is issued while empty.
